// File: rtl/aes_pkg.sv
// Shared definitions for the AES inverse-cipher sequencer: state encoding,
// GF(2^8) arithmetic over 0x11B and block byte-order helpers.
package aes_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_FETCH = 3'd1;
    localparam state_t S_INIT  = 3'd2;
    localparam state_t S_ROUND = 3'd3;
    localparam state_t S_FINAL = 3'd4;
    localparam state_t S_DONE  = 3'd5;

    function automatic bit rounds_ok(input int rounds);
        return (rounds == 10) || (rounds == 12) || (rounds == 14);
    endfunction

    // Byte 0 of a block occupies bits [127:120].
    function automatic logic [7:0] get_byte(input logic [127:0] blk, input int idx);
        return blk[127-8*idx -: 8];
    endfunction

    function automatic logic [7:0] gf_xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = gf_xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] gf_mul_09(input logic [7:0] b); return gf_mul(b, 8'h09); endfunction
    function automatic logic [7:0] gf_mul_0b(input logic [7:0] b); return gf_mul(b, 8'h0b); endfunction
    function automatic logic [7:0] gf_mul_0d(input logic [7:0] b); return gf_mul(b, 8'h0d); endfunction
    function automatic logic [7:0] gf_mul_0e(input logic [7:0] b); return gf_mul(b, 8'h0e); endfunction

    // a^254 is the multiplicative inverse, and maps 0 to 0 as the S-box needs.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) r = gf_mul(r, p);
            p = gf_mul(p, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] t;
        t = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        return gf_inv(t);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {gf_mul_0e(a0) ^ gf_mul_0b(a1) ^ gf_mul_0d(a2) ^ gf_mul_09(a3),
                gf_mul_09(a0) ^ gf_mul_0e(a1) ^ gf_mul_0b(a2) ^ gf_mul_0d(a3),
                gf_mul_0d(a0) ^ gf_mul_09(a1) ^ gf_mul_0e(a2) ^ gf_mul_0b(a3),
                gf_mul_0b(a0) ^ gf_mul_0d(a1) ^ gf_mul_09(a2) ^ gf_mul_0e(a3)};
    endfunction

endpackage

// File: rtl/aes_dec_round.sv
// Combinational inverse round: InvShiftRows, InvSubBytes, AddRoundKey and,
// except on the last round, InvMixColumns.
module aes_dec_round
    import aes_pkg::*;
(
    input  logic [127:0] st_i,
    input  logic [127:0] rk_i,
    input  logic         last_i,
    output logic [127:0] res_o
);

    logic [127:0] sr;
    logic [127:0] sb;
    logic [127:0] ark;
    logic [127:0] mc;

    // Row r rotates right by r columns; byte r+4c is row r of column c.
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign sr[127-8*(r+4*c) -: 8] = get_byte(st_i, r + 4*((c + 4 - r) % 4));
        end
        assign mc[127-32*c -: 32] = inv_mix_col(ark[127-32*c -: 32]);
    end

    dec_subbytes u_subbytes (
        .data_i (sr),
        .data_o (sb)
    );

    assign ark   = sb ^ rk_i;
    assign res_o = last_i ? ark : mc;

endmodule

// File: rtl/dec_subbytes.sv
// InvSubBytes over a full 128-bit block.
module dec_subbytes
    import aes_pkg::*;
(
    input  logic [127:0] data_i,
    output logic [127:0] data_o
);

    for (genvar i = 0; i < 16; i++) begin : g_byte
        assign data_o[8*i +: 8] = inv_sbox(data_i[8*i +: 8]);
    end

endmodule

// File: rtl/aes_dec_ctrl.sv
// Iterative AES inverse-cipher sequencer: one round per clock, round keys
// streamed from an external synchronous RAM, highest index first.
module aes_dec_ctrl
    import aes_pkg::*;
#(
    parameter int ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         rk_rd_en,
    output logic [3:0]   rk_addr,
    input  logic [127:0] rk_data,
    output logic         busy
);

    if (!rounds_ok(ROUNDS)) begin : g_bad_rounds
        $fatal(1, "aes_dec_ctrl: ROUNDS must be 10, 12 or 14");
    end

    localparam logic [3:0] RK_TOP    = 4'(ROUNDS);
    localparam logic [3:0] RK_TOP_M1 = 4'(ROUNDS - 1);
    localparam logic [3:0] RK_TOP_M2 = 4'(ROUNDS - 2);

    state_t       state_q, state_d;
    logic [127:0] ct_q, ct_d;
    logic [127:0] st_q, st_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [3:0]   rk_addr_q, rk_addr_d;
    logic         rk_rd_en_q, rk_rd_en_d;
    logic         out_valid_q, out_valid_d;
    logic [127:0] out_data_q, out_data_d;
    logic [127:0] round_out;

    aes_dec_round u_round (
        .st_i   (st_q),
        .rk_i   (rk_data),
        .last_i (state_q == S_FINAL),
        .res_o  (round_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ct_q        <= '0;
            st_q        <= '0;
            rnd_q       <= '0;
            rk_addr_q   <= '0;
            rk_rd_en_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            ct_q        <= ct_d;
            st_q        <= st_d;
            rnd_q       <= rnd_d;
            rk_addr_q   <= rk_addr_d;
            rk_rd_en_q  <= rk_rd_en_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid) state_d = S_FETCH;
            S_FETCH: state_d = S_INIT;
            S_INIT:  state_d = S_ROUND;
            S_ROUND: if (rnd_q == 4'd1) state_d = S_FINAL;
            S_FINAL: state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // The RAM answers one cycle after each address, so the address runs two
    // steps ahead of the round that consumes the key.
    always_comb begin
        ct_d        = ct_q;
        st_d        = st_q;
        rnd_d       = rnd_q;
        rk_addr_d   = rk_addr_q;
        rk_rd_en_d  = rk_rd_en_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    ct_d       = in_data;
                    rk_addr_d  = RK_TOP;
                    rk_rd_en_d = 1'b1;
                end
            end
            S_FETCH: rk_addr_d = RK_TOP_M1;
            S_INIT: begin
                st_d      = ct_q ^ rk_data;
                rk_addr_d = RK_TOP_M2;
                rnd_d     = RK_TOP_M1;
            end
            S_ROUND: begin
                st_d = round_out;
                if (rnd_q != 4'd1) rnd_d = rnd_q - 4'd1;
                if (rk_addr_q == 4'd0) rk_rd_en_d = 1'b0;
                else                   rk_addr_d  = rk_addr_q - 4'd1;
            end
            S_FINAL: begin
                out_data_d  = round_out;
                out_valid_d = 1'b1;
            end
            S_DONE: if (out_ready) out_valid_d = 1'b0;
            default: ;
        endcase
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign rk_rd_en  = rk_rd_en_q;
    assign rk_addr   = rk_addr_q;

endmodule

// File: tb/tb_aes_dec_ctrl.sv
// Directed bench for aes_dec_ctrl: FIPS-197 vectors on a ROUNDS=10 and a
// ROUNDS=14 instance, each fed by a synchronous round-key RAM model.
module tb_aes_dec_ctrl;

    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [255:0] KEY_C1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KEY_B  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0;
    logic         a_rk_rd_en, a_busy;
    logic [127:0] a_in_data = '0, a_out_data, a_rk_data = '0;
    logic [3:0]   a_rk_addr;
    logic         b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0;
    logic         b_rk_rd_en, b_busy;
    logic [127:0] b_in_data = '0, b_out_data, b_rk_data = '0;
    logic [3:0]   b_rk_addr;

    aes_dec_ctrl #(.ROUNDS(10)) u_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .rk_rd_en(a_rk_rd_en), .rk_addr(a_rk_addr), .rk_data(a_rk_data), .busy(a_busy));

    aes_dec_ctrl #(.ROUNDS(14)) u_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .rk_rd_en(b_rk_rd_en), .rk_addr(b_rk_addr), .rk_data(b_rk_data), .busy(b_busy));

    logic [127:0] rka [0:15];
    logic [127:0] rkb [0:15];
    logic [31:0]  w   [0:59];
    logic [7:0]   sbox [0:255];

    always @(posedge clk) begin
        if (a_rk_rd_en) a_rk_data <= rka[a_rk_addr];
        if (b_rk_rd_en) b_rk_data <= rkb[b_rk_addr];
    end

    int n_cmp = 0;
    int n_err = 0;

    // Round-key stream monitor: per block, ROUNDS+1 consecutive reads, addresses ROUNDS..0.
    int         a_run = 0, a_blocks = 0, b_run = 0, b_blocks = 0;
    logic [3:0] a_prev = '0, b_prev = '0;
    bit         a_bad = 1'b0, b_bad = 1'b0;
    always @(posedge clk) begin
        if (rst) begin
            a_run <= 0;
            b_run <= 0;
        end else begin
            if (a_rk_rd_en === 1'b1) begin
                if (a_run == 0 && a_rk_addr != 4'd10) a_bad <= 1'b1;
                if (a_run != 0 && a_rk_addr != a_prev - 4'd1) a_bad <= 1'b1;
                a_run <= a_run + 1;
                a_prev <= a_rk_addr;
            end else if (a_run != 0) begin
                if (a_run != 11) a_bad <= 1'b1;
                a_blocks <= a_blocks + 1;
                a_run <= 0;
            end
            if (b_rk_rd_en === 1'b1) begin
                if (b_run == 0 && b_rk_addr != 4'd14) b_bad <= 1'b1;
                if (b_run != 0 && b_rk_addr != b_prev - 4'd1) b_bad <= 1'b1;
                b_run <= b_run + 1;
                b_prev <= b_rk_addr;
            end else if (b_run != 0) begin
                if (b_run != 15) b_bad <= 1'b1;
                b_blocks <= b_blocks + 1;
                b_run <= 0;
            end
        end
    end

    function automatic logic [7:0] tmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (tmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                      ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    task automatic expand_key(input logic [255:0] key, input int nk, input int nr);
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
    endtask

    task automatic load_a(input logic [255:0] key);
        expand_key(key, 4, 10);
        for (int r = 0; r <= 10; r++) rka[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic load_b(input logic [255:0] key);
        expand_key(key, 8, 14);
        for (int r = 0; r <= 14; r++) rkb[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", a_in_ready); end
        n_cmp++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", a_busy); end
        n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", a_out_valid); end
        n_cmp++; if (a_out_data !== 128'h0) begin n_err++; $display("FAIL rst_out_data: got %h want 0", a_out_data); end
        n_cmp++; if ({a_rk_rd_en, a_rk_addr} !== 5'h00) begin n_err++; $display("FAIL rst_rk: got %b/%0d want 0/0", a_rk_rd_en, a_rk_addr); end
        n_cmp++; if ({b_in_ready, b_busy, b_out_valid} !== 3'b100) begin n_err++; $display("FAIL rst_b: got %b want 100", {b_in_ready, b_busy, b_out_valid}); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_c1();
        int lat, nrd;
        bit seq_ok;
        a_in_data = CT_C1; a_in_valid = 1'b1; a_out_ready = 1'b0;
        @(negedge clk);
        a_in_valid = 1'b0; a_in_data = ~CT_C1;
        lat = 0; nrd = 0; seq_ok = 1'b1;
        while (a_out_valid !== 1'b1 && lat < 40) begin
            if (a_rk_rd_en === 1'b1) begin
                if (a_rk_addr !== 4'(10 - nrd)) seq_ok = 1'b0;
                nrd++;
            end
            @(negedge clk);
            lat++;
        end
        n_cmp++; if (lat != 12) begin n_err++; $display("FAIL c1_latency: got %0d want 12", lat); end
        n_cmp++; if (a_out_data !== PT_C) begin n_err++; $display("FAIL c1_data: got %h want %h", a_out_data, PT_C); end
        n_cmp++; if (nrd != 11 || !seq_ok) begin n_err++; $display("FAIL c1_rk_seq: reads %0d ordered %b want 11 1", nrd, seq_ok); end
        n_cmp++; if ({a_busy, a_in_ready} !== 2'b10) begin n_err++; $display("FAIL c1_busy: got %b want 10", {a_busy, a_in_ready}); end
        a_out_ready = 1'b1;
        @(negedge clk);
        a_out_ready = 1'b0;
        n_cmp++; if ({a_out_valid, a_in_ready} !== 2'b01) begin n_err++; $display("FAIL c1_release: got %b want 01", {a_out_valid, a_in_ready}); end
    endtask

    task automatic test_c3();
        int lat, nrd;
        bit seq_ok;
        b_in_data = CT_C3; b_in_valid = 1'b1; b_out_ready = 1'b0;
        @(negedge clk);
        b_in_valid = 1'b0; b_in_data = '0;
        lat = 0; nrd = 0; seq_ok = 1'b1;
        while (b_out_valid !== 1'b1 && lat < 40) begin
            if (b_rk_rd_en === 1'b1) begin
                if (b_rk_addr !== 4'(14 - nrd)) seq_ok = 1'b0;
                nrd++;
            end
            @(negedge clk);
            lat++;
        end
        n_cmp++; if (lat != 16) begin n_err++; $display("FAIL c3_latency: got %0d want 16", lat); end
        n_cmp++; if (b_out_data !== PT_C) begin n_err++; $display("FAIL c3_data: got %h want %h", b_out_data, PT_C); end
        n_cmp++; if (nrd != 15 || !seq_ok) begin n_err++; $display("FAIL c3_rk_seq: reads %0d ordered %b want 15 1", nrd, seq_ok); end
        b_out_ready = 1'b1;
        @(negedge clk);
        b_out_ready = 1'b0;
        n_cmp++; if ({b_out_valid, b_in_ready} !== 2'b01) begin n_err++; $display("FAIL c3_release: got %b want 01", {b_out_valid, b_in_ready}); end
    endtask

    task automatic test_backpressure();
        int k;
        bit stable, rdy_low;
        a_in_data = CT_C1; a_in_valid = 1'b1; a_out_ready = 1'b0;
        @(negedge clk);
        a_in_valid = 1'b0;
        k = 0;
        while (a_out_valid !== 1'b1 && k < 40) begin @(negedge clk); k++; end
        n_cmp++; if (a_out_valid !== 1'b1) begin n_err++; $display("FAIL bp_timeout: out_valid %b want 1", a_out_valid); end
        stable = 1'b1; rdy_low = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (a_out_data !== PT_C || a_out_valid !== 1'b1) stable = 1'b0;
            if (a_in_ready !== 1'b0) rdy_low = 1'b0;
            a_in_valid = (i == 5); a_in_data = CT_B;
            @(negedge clk);
        end
        a_in_valid = 1'b0;
        n_cmp++; if (!stable) begin n_err++; $display("FAIL bp_stable: got %h/%b want %h/1", a_out_data, a_out_valid, PT_C); end
        n_cmp++; if (!rdy_low) begin n_err++; $display("FAIL bp_in_ready: got high while holding, want 0"); end
        a_out_ready = 1'b1;
        @(negedge clk);
        a_out_ready = 1'b0;
        n_cmp++; if ({a_out_valid, a_in_ready} !== 2'b01) begin n_err++; $display("FAIL bp_release: got %b want 01", {a_out_valid, a_in_ready}); end
        repeat (2) @(negedge clk);
        n_cmp++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL bp_ignored: busy %b want 0", a_busy); end
    endtask

    task automatic test_back_to_back();
        int acc, got;
        int acc_t [2];
        logic [127:0] res [2];
        acc = 0; got = 0;
        acc_t[0] = 0; acc_t[1] = 0; res[0] = '0; res[1] = '0;
        a_in_data = CT_C1; a_in_valid = 1'b1; a_out_ready = 1'b1;
        for (int t = 0; t < 80 && got < 2; t++) begin
            if (a_in_valid && a_in_ready) begin
                if (acc < 2) acc_t[acc] = t;
                acc++;
            end
            if (a_out_valid === 1'b1) begin
                if (got < 2) res[got] = a_out_data;
                got++;
                // Block 1 has finished reading keys; block 2 decrypts under key B.
                if (got == 1) load_a(KEY_B);
            end
            @(negedge clk);
            if (acc >= 1) a_in_data = CT_B;
            if (acc >= 2) a_in_valid = 1'b0;
        end
        a_in_valid = 1'b0; a_out_ready = 1'b0;
        n_cmp++; if (acc != 2 || got != 2) begin n_err++; $display("FAIL b2b_count: accepts %0d results %0d want 2 2", acc, got); end
        n_cmp++; if (acc_t[1] - acc_t[0] != 14) begin n_err++; $display("FAIL b2b_spacing: got %0d want 14", acc_t[1] - acc_t[0]); end
        n_cmp++; if (res[0] !== PT_C) begin n_err++; $display("FAIL b2b_first: got %h want %h", res[0], PT_C); end
        n_cmp++; if (res[1] !== PT_B) begin n_err++; $display("FAIL b2b_second: got %h want %h", res[1], PT_B); end
        load_a(KEY_C1);
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int lat;
        bit seen;
        a_in_data = CT_C1; a_in_valid = 1'b1; a_out_ready = 1'b0;
        @(negedge clk);
        a_in_valid = 1'b0;
        repeat (6) @(negedge clk);
        n_cmp++; if (a_rk_addr !== 4'd4) begin n_err++; $display("FAIL mid_position: rk_addr %0d want 4", a_rk_addr); end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if ({a_busy, a_in_ready, a_out_valid, a_rk_rd_en} !== 4'b0100) begin
            n_err++; $display("FAIL mid_reset: busy/in_ready/out_valid/rd_en %b want 0100", {a_busy, a_in_ready, a_out_valid, a_rk_rd_en}); end
        n_cmp++; if (a_rk_addr !== 4'd0 || a_out_data !== 128'h0) begin n_err++; $display("FAIL mid_reset_regs: addr %0d data %h want 0 0", a_rk_addr, a_out_data); end
        rst = 1'b0;
        seen = 1'b0;
        repeat (20) begin @(negedge clk); if (a_out_valid !== 1'b0) seen = 1'b1; end
        n_cmp++; if (seen) begin n_err++; $display("FAIL mid_no_output: out_valid pulsed after reset, want none"); end
        a_in_data = CT_C1; a_in_valid = 1'b1;
        @(negedge clk);
        a_in_valid = 1'b0;
        lat = 0;
        while (a_out_valid !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
        n_cmp++; if (lat != 12 || a_out_data !== PT_C) begin n_err++; $display("FAIL mid_rerun: lat %0d data %h want 12 %h", lat, a_out_data, PT_C); end
        a_out_ready = 1'b1;
        @(negedge clk);
        a_out_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_rk_protocol();
        n_cmp++; if (a_bad || b_bad) begin n_err++; $display("FAIL rk_protocol: bad a=%b b=%b want 0 0", a_bad, b_bad); end
        n_cmp++; if (a_blocks != 5 || b_blocks != 1) begin n_err++; $display("FAIL rk_blocks: a %0d b %0d want 5 1", a_blocks, b_blocks); end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        build_sbox();
        load_a(KEY_C1);
        load_b(KEY_C3);
        test_reset();
        test_c1();
        test_c3();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_rk_protocol();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
